div_hilo_sequencer: RTL and testbench
=====================================

Name: div_hilo_sequencer

Overview:
- Multicycle control and writeback stage wrapped around the combinational signed divider.
- Registers the dividend and divisor into the divider and holds them stable for LATENCY cycles, so the divider is a timed multicycle path.
- Then captures the 64-bit divider result {remainder, quotient} into the HI/LO register pair.
- Detects divide-by-zero and provides HI/LO read and direct-write (MTHI/MTLO) paths for the datapath.

Parameters:
- LATENCY, 4: clock cycles the divider operands are held before the result is captured. Legal range 1..15.

Ports:
- clock  input  1  system clock, all state changes on rising edge
- clear  input  1  synchronous, active-low reset
- start  input  1  request a divide; sampled only in IDLE
- op_a  input  32  signed dividend
- op_b  input  32  signed divisor
- div_a  output  32  registered dividend driven to divider A
- div_b  output  32  registered divisor driven to divider B
- div_z  input  64  divider result: [63:32] remainder, [31:0] quotient
- hi_in  input  32  bus data for direct HI write
- lo_in  input  32  bus data for direct LO write
- hi_write  input  1  load HI from hi_in
- lo_write  input  1  load LO from lo_in
- hi_out  output  32  HI register (remainder)
- lo_out  output  32  LO register (quotient)
- busy  output  1  high while a divide is in flight
- done  output  1  one-cycle completion pulse
- div_by_zero  output  1  last accepted start had op_b == 0

Behaviour:
- Reset, when clear=0 at an edge:
  - State goes to IDLE, counter to 0.
  - div_a, div_b, hi_out and lo_out go to 0. busy, done and div_by_zero go to 0.
  - Reset overrides everything else, including mid-divide; an in-flight divide is discarded and HI/LO are not updated.
- States: IDLE, WAIT, FINISH.
- IDLE, start=1, op_b!=0 (edge E0):
  - div_a<=op_a, div_b<=op_b, counter<=LATENCY-1, div_by_zero<=0.
  - Go to WAIT.
- IDLE, start=1, op_b==0 (edge E0):
  - div_by_zero<=1. HI/LO and div_a/div_b are unchanged.
  - Go to FINISH.
- WAIT:
  - busy=1.
  - If counter!=0: counter decrements each edge.
  - If counter==0: hi_out<=div_z[63:32], lo_out<=div_z[31:0], go to FINISH.
  - Capture therefore occurs at edge E0+LATENCY.
- FINISH:
  - done=1 for exactly one cycle, busy=0, go to IDLE.
  - start is ignored in FINISH. Back-to-back accepted starts are at least LATENCY+2 cycles apart.
- Outputs busy and done are decoded from registered state; no combinational path from any input.
- start while in WAIT or FINISH is ignored, with no queuing and no effect on the operation in flight.
- div_a/div_b hold their values after completion until the next accepted non-zero start.
- div_by_zero is sticky until the next accepted start.
- Direct writes:
  - hi_write/lo_write are honoured in any state.
  - If a direct write and the WAIT capture land on the same edge, the capture wins for that register.
  - hi_write and lo_write are independent.
- Arithmetic: no sign manipulation here; div_z passes through bit-exact.
  - Remainder takes the sign of the dividend; quotient truncates toward zero.
  - 0x80000000 / -1 yields whatever the divider produces (quotient 0x80000000, remainder 0); no overflow flag is raised.

Test Plan:
- LATENCY=4, start with op_a=7, op_b=2 -> busy high 4 cycles, lo_out=3 and hi_out=1 at E0+4, done pulses in the following cycle only.
- op_a=-7 (0xFFFFFFF9), op_b=2 -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF. Then op_a=7, op_b=-2 -> lo_out=0xFFFFFFFD, hi_out=0x00000001.
- HI/LO preloaded to 0xAAAA0000/0x5555 via hi_write/lo_write, then start with op_b=0 -> div_by_zero=1, done one cycle after E0, HI/LO unchanged, busy never asserts. A later valid start clears div_by_zero.
- Start 100/7 accepted, second start 50/5 pulsed during WAIT -> only 100/7 result (lo=14, hi=2) captured, div_a stays 100, exactly one done pulse.
- Start 100/7, clear=0 two cycles later -> all outputs 0 next cycle, no done pulse, HI/LO remain 0 after clear releases.
- hi_write=1 with hi_in=0x12345678 on the capture edge of 9/4 -> hi_out=1 (capture wins). A lo_write on a non-capture WAIT edge is applied, then overwritten by the quotient 2.

Source files
------------

// File: rtl/div_hilo_sequencer.sv
// Holds divider operands for LATENCY cycles, then writes {remainder, quotient} into HI/LO.
// Latency: capture LATENCY edges after an accepted start, done one cycle later; starts are dropped while busy.
module div_hilo_sequencer #(
  parameter int unsigned LATENCY = 4
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [63:0] div_z,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  input  logic        hi_write,
  input  logic        lo_write,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] div_a_q, div_a_d;
  logic [31:0] div_b_q, div_b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        dbz_q, dbz_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_a_d = div_a_q;
    div_b_d = div_b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;

    // Direct writes first so the WAIT capture below overrides them on a collision.
    if (hi_write) hi_d = hi_in;
    if (lo_write) lo_d = lo_in;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op_b != 32'd0) begin
            div_a_d = op_a;
            div_b_d = op_b;
            cnt_d   = CNT_INIT;
            dbz_d   = 1'b0;
            state_d = S_WAIT;
          end else begin
            dbz_d   = 1'b1;
            state_d = S_FINISH;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          hi_d    = div_z[63:32];
          lo_d    = div_z[31:0];
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      div_a_q <= 32'd0;
      div_b_q <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_a_q <= div_a_d;
      div_b_q <= div_b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign div_a       = div_a_q;
  assign div_b       = div_b_q;
  assign hi_out      = hi_q;
  assign lo_out      = lo_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q == S_WAIT);
  assign done        = (state_q == S_FINISH);

endmodule

// File: tb/tb_div_hilo_sequencer.sv
// Bench for div_hilo_sequencer: fixed vectors, directed corner sequences and a randomized run against an edge-level reference model.
module tb_div_hilo_sequencer;

  localparam int L = 4;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;
  logic [31:0] div_a, div_b;
  logic [63:0] div_z;
  logic [31:0] hi_in = '0, lo_in = '0;
  logic        hi_write = 1'b0, lo_write = 1'b0;
  logic [31:0] hi_out, lo_out;
  logic        busy, done, div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  // Behavioural signed divider: remainder follows dividend sign, quotient truncates toward zero.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sa = $signed(a);
    sb = $signed(b);
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  assign div_z = ref_div(div_a, div_b);

  div_hilo_sequencer #(.LATENCY(L)) dut (
    .clock(clock), .clear(clear), .start(start), .op_a(op_a), .op_b(op_b),
    .div_a(div_a), .div_b(div_b), .div_z(div_z),
    .hi_in(hi_in), .lo_in(lo_in), .hi_write(hi_write), .lo_write(lo_write),
    .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done),
    .div_by_zero(div_by_zero)
  );

  // Reference model state, advanced once per rising edge from the rules of the block.
  int          edge_n = 0;
  logic [31:0] m_hi = '0, m_lo = '0, m_a = '0, m_b = '0;
  logic        m_dbz = 1'b0, m_pend = 1'b0;
  logic [63:0] m_res = '0;
  int          m_cap = 0, m_done_at = -10, m_next = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic model_edge();
    edge_n++;
    if (!clear) begin
      m_hi = '0; m_lo = '0; m_a = '0; m_b = '0; m_dbz = 1'b0;
      m_pend = 1'b0; m_done_at = -10; m_next = edge_n + 1;
    end else begin
      if (hi_write) m_hi = hi_in;
      if (lo_write) m_lo = lo_in;
      if (m_pend && edge_n == m_cap) begin
        m_hi = m_res[63:32];
        m_lo = m_res[31:0];
        m_pend = 1'b0;
        m_done_at = edge_n;
      end
      if (start && edge_n >= m_next) begin
        if (op_b == 32'd0) begin
          m_dbz = 1'b1;
          m_done_at = edge_n;
          m_next = edge_n + 2;
        end else begin
          m_a = op_a; m_b = op_b; m_dbz = 1'b0;
          m_res = ref_div(op_a, op_b);
          m_pend = 1'b1;
          m_cap = edge_n + L;
          m_next = edge_n + L + 2;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    chk("busy", 64'(busy), 64'(m_pend));
    chk("done", 64'(done), 64'(m_done_at == edge_n));
    chk("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
    chk("hi_out", 64'(hi_out), 64'(m_hi));
    chk("lo_out", 64'(lo_out), 64'(m_lo));
    chk("div_a", 64'(div_a), 64'(m_a));
    chk("div_b", 64'(div_b), 64'(m_b));
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int dones;

    tbl[0] = '{32'd7,          32'd2,          32'h0000_0001, 32'h0000_0003, 1'b0};
    tbl[1] = '{32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    tbl[2] = '{32'd7,          32'hFFFF_FFFE,  32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    tbl[3] = '{32'd100,        32'd7,          32'h0000_0002, 32'h0000_000E, 1'b0};
    tbl[4] = '{32'd9,          32'd4,          32'h0000_0001, 32'h0000_0002, 1'b0};
    tbl[5] = '{32'd55,         32'd0,          32'h0000_0001, 32'h0000_0002, 1'b1};
    tbl[6] = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, 1'b0};
    tbl[7] = '{32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0};

    // Reset state
    clear = 1'b0;
    step(); step();
    chk("rst_hi", 64'(hi_out), 64'd0);
    chk("rst_lo", 64'(lo_out), 64'd0);
    chk("rst_busy_done_dbz", 64'({busy, done, div_by_zero}), 64'd0);
    clear = 1'b1;
    step();

    // Preload HI/LO, then divide by zero
    hi_write = 1'b1; hi_in = 32'hAAAA_0000;
    lo_write = 1'b1; lo_in = 32'h0000_5555;
    step();
    hi_write = 1'b0; lo_write = 1'b0;
    start = 1'b1; op_a = 32'd123; op_b = 32'd0;
    step();
    start = 1'b0;
    chk("dbz_flag", 64'(div_by_zero), 64'd1);
    chk("dbz_done", 64'(done), 64'd1);
    chk("dbz_busy", 64'(busy), 64'd0);
    step();
    chk("dbz_done_once", 64'(done), 64'd0);
    chk("dbz_hi_kept", 64'(hi_out), 64'hAAAA_0000);
    chk("dbz_lo_kept", 64'(lo_out), 64'h0000_5555);

    // Table of plain divides
    foreach (tbl[i]) begin
      start = 1'b1; op_a = tbl[i].a; op_b = tbl[i].b;
      step();
      start = 1'b0;
      for (int k = 0; k < L + 2; k++) step();
      chk($sformatf("vec%0d_hi", i), 64'(hi_out), 64'(tbl[i].hi));
      chk($sformatf("vec%0d_lo", i), 64'(lo_out), 64'(tbl[i].lo));
      chk($sformatf("vec%0d_dbz", i), 64'(div_by_zero), 64'(tbl[i].dbz));
    end

    // Second start during WAIT is ignored
    start = 1'b1; op_a = 32'd100; op_b = 32'd7;
    step();
    start = 1'b0;
    step();
    start = 1'b1; op_a = 32'd50; op_b = 32'd5;
    step();
    start = 1'b0;
    dones = 0;
    for (int k = 0; k < L + 2; k++) begin
      step();
      if (done) dones++;
    end
    chk("ign_div_a", 64'(div_a), 64'd100);
    chk("ign_lo", 64'(lo_out), 64'd14);
    chk("ign_hi", 64'(hi_out), 64'd2);
    chk("ign_done_count", 64'(dones), 64'd1);

    // Reset in the middle of a divide
    start = 1'b1; op_a = 32'd100; op_b = 32'd7;
    step();
    start = 1'b0;
    step();
    clear = 1'b0;
    step();
    chk("midrst_outs", 64'({busy, done, div_by_zero}), 64'd0);
    chk("midrst_hilo", {hi_out, lo_out}, 64'd0);
    chk("midrst_ops", {div_a, div_b}, 64'd0);
    clear = 1'b1;
    dones = 0;
    for (int k = 0; k < L + 2; k++) begin
      step();
      if (done) dones++;
    end
    chk("midrst_no_done", 64'(dones), 64'd0);
    chk("midrst_hilo_after", {hi_out, lo_out}, 64'd0);

    // Direct writes during WAIT: lo on a non-capture edge, hi on the capture edge
    start = 1'b1; op_a = 32'd9; op_b = 32'd4;
    step();
    start = 1'b0;
    lo_write = 1'b1; lo_in = 32'hDEAD_BEEF;
    step();
    lo_write = 1'b0;
    chk("wr_lo_applied", 64'(lo_out), 64'hDEAD_BEEF);
    for (int k = 2; k < L; k++) step();
    hi_write = 1'b1; hi_in = 32'h1234_5678;
    step();
    hi_write = 1'b0;
    chk("cap_wins_hi", 64'(hi_out), 64'd1);
    chk("cap_lo", 64'(lo_out), 64'd2);
    chk("cap_done", 64'(done), 64'd1);
    step();

    // Randomized run
    for (int c = 0; c < 600; c++) begin
      clear    = ($urandom_range(0, 99) != 0);
      start    = ($urandom_range(0, 3) == 0);
      hi_write = ($urandom_range(0, 7) == 0);
      lo_write = ($urandom_range(0, 7) == 0);
      hi_in    = $urandom;
      lo_in    = $urandom;
      case ($urandom_range(0, 7))
        0:       begin op_a = $urandom; op_b = 32'd0; end
        1:       begin op_a = 32'h8000_0000; op_b = 32'hFFFF_FFFF; end
        2:       begin op_a = $urandom_range(0, 200) - 100; op_b = $urandom_range(0, 20) - 10; end
        default: begin op_a = $urandom; op_b = $urandom; end
      endcase
      step();
    end
    clear = 1'b1; start = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
    for (int k = 0; k < L + 2; k++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
